// File: rtl/load_data_handler_pkg.sv
// Shared definitions for the memory-stage load unit: load op codes (shared
// with the store path), FSM state encodings and small decode helpers.
package load_data_handler_pkg;

    // Load op codes as carried on alucontrolE.
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;

    // Access FSM state encodings.
    localparam logic [1:0] LDH_IDLE  = 2'd0;
    localparam logic [1:0] LDH_REQ   = 2'd1;
    localparam logic [1:0] LDH_WAIT  = 2'd2;
    localparam logic [1:0] LDH_DRAIN = 2'd3;

    // True for any of the five load op codes.
    function automatic logic is_load_op(input logic [7:0] op);
        return (op == EXE_LB_OP)  || (op == EXE_LBU_OP) ||
               (op == EXE_LH_OP)  || (op == EXE_LHU_OP) ||
               (op == EXE_LW_OP);
    endfunction

    // True when the load would raise AdEL: words need a==0, halves need a[0]==0.
    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        if (op == EXE_LW_OP) begin
            mis = (a != 2'b00);
        end else if ((op == EXE_LH_OP) || (op == EXE_LHU_OP)) begin
            mis = a[0];
        end else begin
            mis = 1'b0;
        end
        return mis;
    endfunction

endpackage

// File: rtl/load_data_handler_extend.sv
// load_extend: purely combinational byte/half/word extraction and sign or
// zero extension of a returned SRAM word. Kept standalone so a future
// bypass path can reuse it.
module load_extend
    import load_data_handler_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  a,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte lane.
    always_comb begin
        byte_s = 8'h00;
        case (a)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
    end

    // Select the addressed half-word; only a[1] matters for halves.
    always_comb begin
        half_s = 16'h0000;
        if (a[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extend the selected field according to the load op.
    always_comb begin
        result = 32'h0000_0000;
        case (op)
            EXE_LB_OP:  result = {{24{byte_s[7]}}, byte_s};
            EXE_LBU_OP: result = {24'h00_0000, byte_s};
            EXE_LH_OP:  result = {{16{half_s[15]}}, half_s};
            EXE_LHU_OP: result = {16'h0000, half_s};
            EXE_LW_OP:  result = rdata;
            default:    result = rdata;
        endcase
    end

endmodule

// File: rtl/load_data_handler.sv
// load_data_handler: memory-stage load unit. Captures a load from execute,
// runs the req/addr_ok/data_ok handshake, stalls the pipeline for the
// access and returns the extended result.
// Optional feature: define ADEL_CHECK_EN to raise AdEL on misaligned loads.
module load_data_handler
    import load_data_handler_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        issueE,
    input  logic [7:0]  alucontrolE,
    input  logic [31:0] aluoutE,
    input  logic        flushM,
    output logic        data_sram_req,
    output logic [31:0] data_sram_addr,
    input  logic        data_sram_addr_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        data_sram_data_ok,
    output logic        stallM,
    output logic        load_validM,
    output logic [31:0] loadresultM,
    output logic        adelM,
    output logic [31:0] badvaddrM
);

    logic [1:0]  state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic        load_valid_q, load_valid_d;
    logic [31:0] result_q, result_d;
    logic [31:0] ext_result_s;
    logic        issue_load_s;
    logic        misalign_s;

    // A load is only accepted in IDLE and only when not being squashed.
    always_comb begin
        issue_load_s = (state_q == LDH_IDLE) && issueE &&
                       is_load_op(alucontrolE) && !flushM;
    end

    // Misalignment only blocks the access when the AdEL check is built in.
    always_comb begin
`ifdef ADEL_CHECK_EN
        misalign_s = is_misaligned(alucontrolE, aluoutE[1:0]);
`else
        misalign_s = 1'b0;
`endif
    end

    load_extend u_load_extend (
        .op     (op_q),
        .a      (addr_q[1:0]),
        .rdata  (data_sram_rdata),
        .result (ext_result_s)
    );

    // Access FSM next-state and capture logic.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        load_valid_d = 1'b0;
        result_d     = result_q;
        case (state_q)
            LDH_IDLE: begin
                if (issue_load_s && !misalign_s) begin
                    op_d    = alucontrolE;
                    addr_d  = aluoutE;
                    state_d = LDH_REQ;
                end else begin
                    state_d = LDH_IDLE;
                end
            end
            LDH_REQ: begin
                // Once addr_ok is seen the data will come back and must be drained.
                if (flushM) begin
                    state_d = data_sram_addr_ok ? LDH_DRAIN : LDH_IDLE;
                end else if (data_sram_addr_ok) begin
                    state_d = LDH_WAIT;
                end else begin
                    state_d = LDH_REQ;
                end
            end
            LDH_WAIT: begin
                if (data_sram_data_ok) begin
                    state_d = LDH_IDLE;
                    if (!flushM) begin
                        load_valid_d = 1'b1;
                        result_d     = ext_result_s;
                    end else begin
                        result_d = result_q;
                    end
                end else if (flushM) begin
                    state_d = LDH_DRAIN;
                end else begin
                    state_d = LDH_WAIT;
                end
            end
            LDH_DRAIN: begin
                if (data_sram_data_ok) begin
                    state_d = LDH_IDLE;
                end else begin
                    state_d = LDH_DRAIN;
                end
            end
            default: begin
                state_d = LDH_IDLE;
            end
        endcase
    end

    // Access FSM and result registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= LDH_IDLE;
            op_q         <= 8'h00;
            addr_q       <= 32'h0000_0000;
            load_valid_q <= 1'b0;
            result_q     <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            load_valid_q <= load_valid_d;
            result_q     <= result_d;
        end
    end

`ifdef ADEL_CHECK_EN
    logic        adel_q, adel_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    // AdEL pulse on a rejected misaligned load; fault address held until the next fault.
    always_comb begin
        adel_d     = issue_load_s && misalign_s;
        badvaddr_d = badvaddr_q;
        if (adel_d) begin
            badvaddr_d = aluoutE;
        end else begin
            badvaddr_d = badvaddr_q;
        end
    end

    // AdEL registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            adel_q     <= 1'b0;
            badvaddr_q <= 32'h0000_0000;
        end else begin
            adel_q     <= adel_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    assign adelM     = adel_q;
    assign badvaddrM = badvaddr_q;
`else
    assign adelM     = 1'b0;
    assign badvaddrM = 32'h0000_0000;
`endif

    assign data_sram_req  = (state_q == LDH_REQ);
    assign data_sram_addr = {addr_q[31:2], 2'b00};
    assign stallM         = (state_q != LDH_IDLE);
    assign load_validM    = load_valid_q;
    assign loadresultM    = result_q;

endmodule

// File: tb/tb_load_data_handler.sv
// Self-checking bench for load_data_handler: directed handshake/flush/reset
// scenarios plus randomized loads against a behavioural reference model.
module tb_load_data_handler;

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_NOP = 8'h00;

    logic        clk;
    logic        resetn;
    logic        issueE;
    logic [7:0]  alucontrolE;
    logic [31:0] aluoutE;
    logic        flushM;
    logic        data_sram_req;
    logic [31:0] data_sram_addr;
    logic        data_sram_addr_ok;
    logic [31:0] data_sram_rdata;
    logic        data_sram_data_ok;
    logic        stallM;
    logic        load_validM;
    logic [31:0] loadresultM;
    logic        adelM;
    logic [31:0] badvaddrM;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_result;
    logic [31:0] exp_badv;

    load_data_handler dut (
        .clk               (clk),
        .resetn            (resetn),
        .issueE            (issueE),
        .alucontrolE       (alucontrolE),
        .aluoutE           (aluoutE),
        .flushM            (flushM),
        .data_sram_req     (data_sram_req),
        .data_sram_addr    (data_sram_addr),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_rdata   (data_sram_rdata),
        .data_sram_data_ok (data_sram_data_ok),
        .stallM            (stallM),
        .load_validM       (load_validM),
        .loadresultM       (loadresultM),
        .adelM             (adelM),
        .badvaddrM         (badvaddrM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: pick the addressed byte/half with shifts and extend by value.
    function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] b;
        logic [31:0] h;
        int unsigned off;
        off = addr % 4;
        b = (word >> (8 * off)) & 32'h0000_00FF;
        h = (word >> (16 * (off / 2))) & 32'h0000_FFFF;
        case (op)
            OP_LB:   return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            OP_LHU:  return h;
            OP_LW:   return word;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic ref_adel(input logic [7:0] op, input logic [31:0] addr);
`ifdef ADEL_CHECK_EN
        return ((op == OP_LW) && (addr % 4 != 0)) ||
               (((op == OP_LH) || (op == OP_LHU)) && (addr % 2 == 1));
`else
        return 1'b0;
`endif
    endfunction

    // One complete load: issue, aw cycles of addr_ok delay, dw cycles of data_ok delay.
    task automatic do_load(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] word,
                           input int aw, input int dw);
        int stall_cnt;
        stall_cnt   = 0;
        issueE      = 1'b1;
        alucontrolE = op;
        aluoutE     = addr;
        step();
        issueE      = 1'b0;
        alucontrolE = OP_NOP;
        if (ref_adel(op, addr)) begin
            exp_badv = addr;
            check("adel_pulse", {31'd0, adelM}, 32'd1);
            check("adel_no_req", {31'd0, data_sram_req}, 32'd0);
            check("adel_no_stall", {31'd0, stallM}, 32'd0);
            check("adel_badv", badvaddrM, exp_badv);
            step();
            check("adel_drop", {31'd0, adelM}, 32'd0);
            check("adel_badv_hold", badvaddrM, exp_badv);
        end else begin
            check("req_cycle1", {31'd0, data_sram_req}, 32'd1);
            check("req_addr", data_sram_addr, addr & 32'hFFFF_FFFC);
            check("no_adel", {31'd0, adelM}, 32'd0);
            check("badv_hold", badvaddrM, exp_badv);
            for (int i = 0; i < aw; i++) begin
                stall_cnt += int'(stallM);
                step();
            end
            check("req_held", {31'd0, data_sram_req}, 32'd1);
            check("addr_stable", data_sram_addr, addr & 32'hFFFF_FFFC);
            data_sram_addr_ok = 1'b1;
            stall_cnt += int'(stallM);
            step();
            data_sram_addr_ok = 1'b0;
            check("req_drop", {31'd0, data_sram_req}, 32'd0);
            for (int i = 0; i < dw; i++) begin
                stall_cnt += int'(stallM);
                step();
            end
            check("no_early_valid", {31'd0, load_validM}, 32'd0);
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = word;
            stall_cnt += int'(stallM);
            step();
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = $urandom;
            exp_result = ref_load(op, addr, word);
            check("valid_pulse", {31'd0, load_validM}, 32'd1);
            check("result", loadresultM, exp_result);
            check("stall_off", {31'd0, stallM}, 32'd0);
            check("stall_cycles", stall_cnt, 2 + aw + dw);
            step();
            check("valid_drop", {31'd0, load_validM}, 32'd0);
            check("result_hold", loadresultM, exp_result);
        end
    endtask

    // Issue a load and advance into REQ without completing it.
    task automatic start_load(input logic [7:0] op, input logic [31:0] addr);
        issueE      = 1'b1;
        alucontrolE = op;
        aluoutE     = addr;
        step();
        issueE      = 1'b0;
        alucontrolE = OP_NOP;
    endtask

    initial begin
        logic [7:0] ops [5];
        n_checks = 0;
        n_fail   = 0;
        exp_result = 32'h0;
        exp_badv   = 32'h0;
        ops[0] = OP_LB; ops[1] = OP_LBU; ops[2] = OP_LH; ops[3] = OP_LHU; ops[4] = OP_LW;
        resetn = 1'b0; issueE = 1'b0; alucontrolE = OP_NOP; aluoutE = 32'h0; flushM = 1'b0;
        data_sram_addr_ok = 1'b0; data_sram_rdata = 32'h0; data_sram_data_ok = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();
        check("rst_req", {31'd0, data_sram_req}, 32'd0);
        check("rst_addr", data_sram_addr, 32'h0);
        check("rst_stall", {31'd0, stallM}, 32'd0);
        check("rst_valid", {31'd0, load_validM}, 32'd0);
        check("rst_result", loadresultM, 32'h0);
        check("rst_adel", {31'd0, adelM}, 32'd0);
        check("rst_badv", badvaddrM, 32'h0);

        // Directed extraction cases.
        do_load(OP_LB,  32'h0000_1003, 32'h80FF_1234, 0, 0);
        check("lb_const", loadresultM, 32'hFFFF_FF80);
        do_load(OP_LBU, 32'h0000_1003, 32'h80FF_1234, 0, 0);
        check("lbu_const", loadresultM, 32'h0000_0080);
        do_load(OP_LH,  32'h0000_2002, 32'h8001_7FFF, 0, 0);
        check("lh_const", loadresultM, 32'hFFFF_8001);
        do_load(OP_LHU, 32'h0000_2000, 32'h8001_7FFF, 0, 0);
        check("lhu_const", loadresultM, 32'h0000_7FFF);
        do_load(OP_LW,  32'h0000_3000, 32'hCAFE_BABE, 2, 3);
        check("lw_const", loadresultM, 32'hCAFE_BABE);
        do_load(OP_LW,  32'h0000_4001, 32'h1234_5678, 0, 0);

        // Non-load op and flush-with-issue are ignored.
        start_load(OP_NOP, 32'h0000_5000);
        check("nonload_no_req", {31'd0, data_sram_req}, 32'd0);
        flushM = 1'b1;
        start_load(OP_LW, 32'h0000_5000);
        flushM = 1'b0;
        check("flush_issue_no_stall", {31'd0, stallM}, 32'd0);

        // Flush in WAIT, data arrives two cycles later.
        start_load(OP_LW, 32'h0000_6000);
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        flushM = 1'b1;
        step();
        flushM = 1'b0;
        check("drain_stall", {31'd0, stallM}, 32'd1);
        check("drain_no_valid", {31'd0, load_validM}, 32'd0);
        step();
        check("drain_still", {31'd0, stallM}, 32'd1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_0001;
        step();
        data_sram_data_ok = 1'b0;
        check("drain_done_stall", {31'd0, stallM}, 32'd0);
        check("drain_done_valid", {31'd0, load_validM}, 32'd0);
        check("drain_result_hold", loadresultM, exp_result);
        do_load(OP_LBU, 32'h0000_6001, 32'h0000_A500, 0, 1);

        // Flush in REQ before addr_ok: no access.
        start_load(OP_LW, 32'h0000_7000);
        flushM = 1'b1;
        step();
        flushM = 1'b0;
        check("req_flush_idle", {31'd0, stallM}, 32'd0);
        check("req_flush_noreq", {31'd0, data_sram_req}, 32'd0);

        // Flush together with addr_ok: drain.
        start_load(OP_LW, 32'h0000_7004);
        flushM = 1'b1;
        data_sram_addr_ok = 1'b1;
        step();
        flushM = 1'b0;
        data_sram_addr_ok = 1'b0;
        check("reqok_flush_drain", {31'd0, stallM}, 32'd1);
        data_sram_data_ok = 1'b1;
        step();
        data_sram_data_ok = 1'b0;
        check("reqok_flush_idle", {31'd0, stallM}, 32'd0);
        check("reqok_flush_novalid", {31'd0, load_validM}, 32'd0);

        // Flush together with data_ok: data discarded.
        start_load(OP_LW, 32'h0000_7008);
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        flushM = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hBAD0_BAD0;
        step();
        flushM = 1'b0;
        data_sram_data_ok = 1'b0;
        check("wait_flush_novalid", {31'd0, load_validM}, 32'd0);
        check("wait_flush_idle", {31'd0, stallM}, 32'd0);
        check("wait_flush_hold", loadresultM, exp_result);

        // Asynchronous reset during REQ.
        start_load(OP_LW, 32'h0000_8000);
        check("pre_rst_req", {31'd0, data_sram_req}, 32'd1);
        resetn = 1'b0;
        #1;
        check("async_rst_req", {31'd0, data_sram_req}, 32'd0);
        check("async_rst_stall", {31'd0, stallM}, 32'd0);
        check("async_rst_result", loadresultM, 32'h0);
        exp_result = 32'h0;
        exp_badv   = 32'h0;
        data_sram_data_ok = 1'b1;
        step();
        resetn = 1'b1;
        step();
        data_sram_data_ok = 1'b0;
        check("late_dataok_novalid", {31'd0, load_validM}, 32'd0);
        check("late_dataok_idle", {31'd0, stallM}, 32'd0);

        // Randomized loads against the reference model.
        for (int n = 0; n < 40; n++) begin
            do_load(ops[$urandom_range(0, 4)], $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
